// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - Shared state type and DMA packet declaration macro for the DMA memory responder.
// BP_ME_DMA_RESP_DELAY_EN adds the e_delay read-latency state.
`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr; \
  } bsg_cache_dma_pkt_s

package bp_me_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0
`ifdef BP_ME_DMA_RESP_DELAY_EN
    , e_delay = 2'd1
`endif
    , e_read  = 2'd2
    , e_write = 2'd3
  } bp_me_dma_resp_state_e;

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - One write port, one asynchronous read port RAM; contents are never reset.
module bsg_mem_1r1w #(
  parameter int width_p = 64,
  parameter int els_p   = 1024,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_dma_mem_responder.sv
// rtl/bp_me_dma_mem_responder.sv - Block-RAM backed responder for the bsg_cache DMA interface of one L2 bank.
// Define BP_ME_DMA_RESP_DELAY_EN to hold each read for delay_p cycles before the first fill beat.
module bp_me_dma_mem_responder
  import bp_me_pkg::*;
#(
  parameter int addr_width_p          = 28,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8,
  parameter int dma_data_width_p      = 64,
  parameter int els_p                 = 1024,
  parameter int delay_p               = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [addr_width_p:0]       dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_ready_and_o,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,
  input  logic [dma_data_width_p-1:0] dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_and_o
);

  localparam int beats_lp          = block_size_in_words_p * data_width_p / dma_data_width_p;
  localparam int cnt_width_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int byte_shift_lp     = $clog2(dma_data_width_p / 8);
  localparam int mem_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  `DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_p);
  bsg_cache_dma_pkt_s dma_pkt;
  assign dma_pkt = dma_pkt_i;

  bp_me_dma_resp_state_e state_r, state_n;
  logic [cnt_width_lp-1:0]      cnt_r, cnt_n;
  logic [mem_addr_width_lp-1:0] base_r, base_n, pkt_base, mem_addr;
  logic cnt_last, pkt_ready, data_v, data_ready, mem_w_v;

`ifdef BP_ME_DMA_RESP_DELAY_EN
  localparam int dly_width_lp = (delay_p > 1) ? $clog2(delay_p) : 1;
  logic [dly_width_lp-1:0] dly_r, dly_n;
`else
  localparam int unused_delay_lp = delay_p;
`endif

  // Beat index of the block start, folded into the RAM depth so high addresses alias.
  assign pkt_base = mem_addr_width_lp'(((dma_pkt.addr >> byte_shift_lp) / beats_lp * beats_lp) % els_p);
  assign cnt_last = (cnt_r == cnt_width_lp'(beats_lp - 1));
  assign mem_addr = base_r + mem_addr_width_lp'(cnt_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
      base_r  <= '0;
`ifdef BP_ME_DMA_RESP_DELAY_EN
      dly_r   <= '0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      base_r  <= base_n;
`ifdef BP_ME_DMA_RESP_DELAY_EN
      dly_r   <= dly_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    base_n     = base_r;
    pkt_ready  = 1'b0;
    data_v     = 1'b0;
    data_ready = 1'b0;
    mem_w_v    = 1'b0;
`ifdef BP_ME_DMA_RESP_DELAY_EN
    dly_n      = dly_r;
`endif
    case (state_r)
      e_ready: begin
        pkt_ready = 1'b1;
        if (dma_pkt_v_i) begin
          base_n = pkt_base;
          if (dma_pkt.write_not_read) begin
            state_n = e_write;
          end else begin
`ifdef BP_ME_DMA_RESP_DELAY_EN
            state_n = e_delay;
            dly_n   = dly_width_lp'(delay_p - 1);
`else
            state_n = e_read;
`endif
          end
        end
      end
`ifdef BP_ME_DMA_RESP_DELAY_EN
      e_delay: begin
        if (dly_r == '0) state_n = e_read;
        else dly_n = dly_r - dly_width_lp'(1);
      end
`endif
      e_read: begin
        data_v = 1'b1;
        if (dma_data_ready_and_i) begin
          cnt_n = cnt_last ? '0 : cnt_r + cnt_width_lp'(1);
          if (cnt_last) state_n = e_ready;
        end
      end
      e_write: begin
        data_ready = 1'b1;
        if (dma_data_v_i) begin
          mem_w_v = 1'b1;
          cnt_n   = cnt_last ? '0 : cnt_r + cnt_width_lp'(1);
          if (cnt_last) state_n = e_ready;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  // Handshake outputs drop as soon as reset asserts, not at the next edge.
  assign dma_pkt_ready_and_o  = pkt_ready & reset_n_i;
  assign dma_data_v_o         = data_v & reset_n_i;
  assign dma_data_ready_and_o = data_ready & reset_n_i;

  bsg_mem_1r1w #(
    .width_p(dma_data_width_p),
    .els_p  (els_p)
  ) mem (
    .w_clk_i (clk_i),
    .w_v_i   (mem_w_v),
    .w_addr_i(mem_addr),
    .w_data_i(dma_data_i),
    .r_addr_i(mem_addr),
    .r_data_o(dma_data_o)
  );

endmodule

// File: tb/tb_bp_me_dma_mem_responder.sv
// tb/tb_bp_me_dma_mem_responder.sv - Self-checking bench for bp_me_dma_mem_responder (BP_ME_DMA_RESP_DELAY_EN aware).
module tb_bp_me_dma_mem_responder;
  localparam int AW = 28, DW = 64, BEATS = 8, ELS = 1024, DELAY = 4;
`ifdef BP_ME_DMA_RESP_DELAY_EN
  localparam int RD_LAT = DELAY + 1;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW:0] pkt = '0;
  logic pkt_v = 1'b0, pkt_ready;
  logic [DW-1:0] rdata, wdata = '0;
  logic rdata_v, rready = 1'b0, wdata_v = 1'b0, wready;

  always #5 clk = ~clk;

  bp_me_dma_mem_responder #(
    .addr_width_p(AW), .data_width_p(64), .block_size_in_words_p(8),
    .dma_data_width_p(DW), .els_p(ELS), .delay_p(DELAY)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_ready_and_o(pkt_ready),
    .dma_data_o(rdata), .dma_data_v_o(rdata_v), .dma_data_ready_and_i(rready),
    .dma_data_i(wdata), .dma_data_v_i(wdata_v), .dma_data_ready_and_o(wready)
  );

  int checks = 0, errors = 0;
  logic [DW-1:0] model [ELS];
  bit written [ELS/BEATS];
  int wblocks [$];

  typedef struct {
    logic [AW-1:0] addr;
    int            exp_base;
    int            mode;
  } rd_vec_t;
  rd_vec_t vecs [7];

  // Byte address -> beat index of the block start, aliased into the RAM depth.
  function automatic int block_base(input logic [AW-1:0] a);
    return ((int'(a) / (DW/8)) / BEATS * BEATS) % ELS;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input logic w, input logic [AW-1:0] a);
    int n;
    n = 0;
    @(negedge clk);
    pkt = {w, a};
    pkt_v = 1'b1;
    #1;
    while (!pkt_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("pkt_accept", pkt_ready, 1);
    @(posedge clk); #1;
    pkt_v = 1'b0;
    pkt = (AW+1)'($urandom);
  endtask

  task automatic write_block(input logic [AW-1:0] a, input bit fixed, input bit stall);
    int base, i, n;
    logic [DW-1:0] d;
    base = block_base(a);
    send_pkt(1'b1, a);
    i = 0; n = 0;
    while (i < BEATS && n < 200) begin
      @(negedge clk);
      d = fixed ? DW'(17 * (i + 1)) : {$urandom, $urandom};
      wdata = d;
      wdata_v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1; n++;
      if (!stall && n == 1) chk("wr_no_delay", wready, 1);
      chk("wr_pkt_ready_low", pkt_ready, 0);
      chk("wr_rdata_v_low", rdata_v, 0);
      if (wdata_v && wready) begin
        model[base + i] = d;
        i++;
      end
    end
    chk("wr_beats_done", i, BEATS);
    @(negedge clk);
    wdata_v = 1'b0;
    #1;
    chk("wr_done_pkt_ready", pkt_ready, 1);
    if (!written[base/BEATS]) begin
      written[base/BEATS] = 1'b1;
      wblocks.push_back(base / BEATS);
    end
  endtask

  // mode 0: ready held high, 1: ready toggles 1,0 from the first valid beat, 2: random ready
  task automatic read_block(input logic [AW-1:0] a, input int exp_base, input int mode);
    int i, n, first_n, last_n;
    bit seen;
    send_pkt(1'b0, a);
    i = 0; n = 0; first_n = 0; last_n = 0; seen = 1'b0;
    rready = 1'b0;
    while (i < BEATS && n < 300) begin
      @(negedge clk);
      n++;
      case (mode)
        0: rready = 1'b1;
        1: rready = (n >= RD_LAT) && ((n - RD_LAT) % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      wdata_v = 1'($urandom_range(0, 1));
      #1;
      chk("rd_evict_not_taken", wready, 0);
      chk("rd_pkt_ready_low", pkt_ready, 0);
      if (!seen && rdata_v) begin
        seen = 1'b1;
        first_n = n;
        chk("rd_latency", n, RD_LAT);
      end
      if (seen) begin
        chk("rd_v", rdata_v, 1);
        chk("rd_beat", rdata, model[exp_base + i]);
        if (rready) begin
          i++;
          last_n = n;
        end
      end
    end
    chk("rd_beats_done", i, BEATS);
    if (mode == 0) chk("rd_consecutive", last_n - first_n + 1, BEATS);
    if (mode == 1) chk("rd_toggle_span", last_n - first_n + 1, 2 * BEATS - 1);
    @(negedge clk);
    rready = 1'b0;
    wdata_v = 1'b0;
    #1;
    chk("rd_done_pkt_ready", pkt_ready, 1);
    chk("rd_done_v_low", rdata_v, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, n, blk;
    logic [AW-1:0] a;

    vecs[0] = '{28'h0000040, 8, 0};
    vecs[1] = '{28'h0000040, 8, 1};
    vecs[2] = '{28'h0000047, 8, 0};
    vecs[3] = '{28'h0010040, 8, 0};
    vecs[4] = '{28'h000007F, 8, 2};
    vecs[5] = '{28'h0000080, 16, 0};
    vecs[6] = '{28'h10000BF, 16, 1};

    // Reset state with handshakes offered
    pkt_v = 1'b1;
    wdata_v = 1'b1;
    #2;
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_rdata_v", rdata_v, 0);
    chk("rst_wready", wready, 0);
    @(negedge clk); #1;
    chk("rst_pkt_ready_2", pkt_ready, 0);
    pkt_v = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_pkt_ready", pkt_ready, 1);
    chk("idle_rdata_v", rdata_v, 0);
    chk("idle_evict_not_taken", wready, 0);
    wdata_v = 1'b0;

    write_block(28'h0000040, 1'b1, 1'b0);
    write_block(28'h0000080, 1'b0, 1'b1);
    chk("pattern_beat0", model[8], 64'h11);
    chk("pattern_beat7", model[15], 64'h88);

    for (int k = 0; k < 7; k++) read_block(vecs[k].addr, vecs[k].exp_base, vecs[k].mode);

    // Reset while beat 3 of a read is presented
    send_pkt(1'b0, 28'h0000040);
    i = 0; n = 0;
    rready = 1'b1;
    while (i < 3 && n < 50) begin
      @(negedge clk); #1; n++;
      if (rdata_v) i++;
    end
    @(negedge clk); #1;
    chk("midrst_pre_v", rdata_v, 1);
    chk("midrst_pre_beat3", rdata, 64'h44);
    rst_n = 1'b0;
    #1;
    chk("midrst_pkt_ready", pkt_ready, 0);
    chk("midrst_rdata_v", rdata_v, 0);
    chk("midrst_wready", wready, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    rready = 1'b0;
    @(negedge clk); #1;
    chk("postrst_pkt_ready", pkt_ready, 1);
    chk("postrst_rdata_v", rdata_v, 0);
    read_block(28'h0000040, 8, 0);

    // Randomized traffic against the address/data model
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = AW'($urandom);
        write_block(a, 1'b0, 1'b1);
      end else begin
        blk = wblocks[$urandom_range(0, wblocks.size() - 1)];
        a = AW'(blk * 64 + $urandom_range(0, 63) + $urandom_range(0, 1023) * 65536);
        read_block(a, block_base(a), 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
